// File: rtl/imm_extend_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : arm_imm_pkg                                                |
// | Brief   : Shared types and constants for the ARM immediate unit.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package arm_imm_pkg;

  // Immediate mode select; 3'b101..3'b111 are illegal encodings.
  typedef enum logic [2:0] {
    IMM_DP8   = 3'b000,
    IMM_MEM12 = 3'b001,
    IMM_BR24  = 3'b010,
    IMM_DPROT = 3'b011,
    IMM_HALF  = 3'b100
  } imm_src_t;

  // Control state: idle / iterative rotation in progress.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ROT  = 1'b1
  } state_t;

  // The data-processing rotate always acts on a 32-bit field.
  localparam int ROT_FIELD_W = 32;
  // Rotate amounts (and the remainder counter) are 5 bits wide.
  localparam int ROT_AMT_W   = 5;

  // Rotate amount encoded in instr[11:8] is twice the field value.
  function automatic logic [ROT_AMT_W-1:0] rot_amount(input logic [3:0] rot4);
    return {rot4, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_extend_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : imm_extend_unit_if                                       |
// | Brief     : Request/result handshake bundle of the immediate unit.   |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface imm_extend_unit_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [23:0]       instr;
  logic [2:0]        imm_src;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_imm;
  logic              shift_c;
  logic              shift_cv;
  logic              imm_err;
  logic [TAG_W-1:0]  out_tag;

  // Decode side: issues requests, consumes results.
  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, ext_imm, shift_c, shift_cv, imm_err, out_tag
  );

  // Immediate unit side.
  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, ext_imm, shift_c, shift_cv, imm_err, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/imm_extend_unit_rot32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : imm_rot32                                                   |
// | Brief  : Combinational 32-bit rotate-right with shifter carry-out.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module imm_rot32 (
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  output logic [31:0] result,
  output logic        carry
);
  // Right rotate as two shifts; a zero amount makes the left shift 32 -> 0.
  always_comb begin
    result = (data >> amount) | (data << (6'd32 - {1'b0, amount}));
    carry  = result[31];
  end
endmodule
`default_nettype wire

// File: rtl/imm_extend_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : imm_extend_unit                                             |
// | Brief  : ARM immediate generator with iterative imm8 rotator,        |
// |          shifter carry-out and valid/ready on both sides.            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module imm_extend_unit
  import arm_imm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ROT_STEP = 32,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  imm_extend_unit_if.slave bus
);

  // Step size for comparisons (6 bits holds 32) and as a rotate amount.
  // ROT_STEP=32 never reaches the iterative path since r <= 30.
  localparam logic [5:0]           STEP_CMP = 6'(ROT_STEP);
  localparam logic [ROT_AMT_W-1:0] STEP_AMT = 5'(ROT_STEP % ROT_FIELD_W);

  state_t                 state;
  state_t                 next_state;
  logic [ROT_FIELD_W-1:0] work;
  logic [ROT_AMT_W-1:0]   rem;
  logic [TAG_W-1:0]       tag_hold;

  logic                   out_valid_q;
  logic [DATA_W-1:0]      ext_imm_q;
  logic                   shift_c_q;
  logic                   shift_cv_q;
  logic                   imm_err_q;
  logic [TAG_W-1:0]       out_tag_q;

  logic [ROT_AMT_W-1:0]   in_rot;
  logic                   accept;
  logic                   long_rot;
  logic                   rem_more;
  logic                   load_out;
  logic                   load_work;
  logic [ROT_FIELD_W-1:0] rot_in;
  logic [ROT_AMT_W-1:0]   rot_amt;
  logic [ROT_FIELD_W-1:0] rot_out;
  logic                   rot_carry;

  logic [DATA_W-1:0]      res_ext;
  logic                   res_c;
  logic                   res_cv;
  logic                   res_err;
  logic [TAG_W-1:0]       res_tag;

  assign in_rot   = rot_amount(bus.instr[11:8]);
  assign long_rot = (bus.imm_src == IMM_DPROT) && ({1'b0, in_rot} > STEP_CMP);
  assign rem_more = ({1'b0, rem} > STEP_CMP);

  // Accept only when idle and the output slot is free or draining now.
  assign bus.in_ready = reset_n & (state == IDLE) & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  // Single rotator shared by the first step in IDLE and the ROT iterations.
  imm_rot32 u_rot (
    .data   (rot_in),
    .amount (rot_amt),
    .result (rot_out),
    .carry  (rot_carry)
  );

  // State register; reset discards any in-flight rotation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: long rotates detour through ROT until the remainder fits.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && long_rot) next_state = ROT;
      ROT:     if (!rem_more)          next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs: rotator operands and register load strobes.
  always_comb begin
    load_out  = 1'b0;
    load_work = 1'b0;
    rot_in    = {24'd0, bus.instr[7:0]};
    rot_amt   = long_rot ? STEP_AMT : in_rot;
    case (state)
      IDLE: begin
        if (accept) begin
          load_work = long_rot;
          load_out  = ~long_rot;
        end
      end
      ROT: begin
        rot_in    = work;
        rot_amt   = rem_more ? STEP_AMT : rem;
        load_work = rem_more;
        load_out  = ~rem_more;
      end
      default: ;
    endcase
  end

  // Result selection: final rotate step in ROT, or the mode decode in IDLE.
  always_comb begin
    res_ext = '0;
    res_c   = 1'b0;
    res_cv  = 1'b0;
    res_err = 1'b0;
    res_tag = bus.in_tag;
    if (state == ROT) begin
      // Only rotates longer than one step get here, so r is non-zero.
      res_ext = DATA_W'(rot_out);
      res_c   = rot_carry;
      res_cv  = 1'b1;
      res_tag = tag_hold;
    end else begin
      case (bus.imm_src)
        IMM_DP8:   res_ext = DATA_W'(bus.instr[7:0]);
        IMM_MEM12: res_ext = DATA_W'(bus.instr[11:0]);
        IMM_BR24:  res_ext = {{(DATA_W-24){bus.instr[23]}}, bus.instr} << 2;
        IMM_DPROT: begin
          res_ext = DATA_W'(rot_out);
          res_cv  = (in_rot != '0);
          res_c   = (in_rot != '0) & rot_carry;
        end
        IMM_HALF:  res_ext = DATA_W'({bus.instr[11:8], bus.instr[3:0]});
        default:   res_err = 1'b1;
      endcase
    end
  end

  // Rotation working registers: partial result, remaining amount, tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work     <= '0;
      rem      <= '0;
      tag_hold <= '0;
    end else if (load_work) begin
      work <= rot_out;
      if (state == IDLE) begin
        rem      <= in_rot - STEP_AMT;
        tag_hold <= bus.in_tag;
      end else begin
        rem <= rem - STEP_AMT;
      end
    end
  end

  // Output registers: load on completion, hold while stalled, clear on drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      ext_imm_q   <= '0;
      shift_c_q   <= 1'b0;
      shift_cv_q  <= 1'b0;
      imm_err_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      ext_imm_q   <= res_ext;
      shift_c_q   <= res_c;
      shift_cv_q  <= res_cv;
      imm_err_q   <= res_err;
      out_tag_q   <= res_tag;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.ext_imm   = ext_imm_q;
  assign bus.shift_c   = shift_c_q;
  assign bus.shift_cv  = shift_cv_q;
  assign bus.imm_err   = imm_err_q;
  assign bus.out_tag   = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_imm_extend_unit                                          |
// | Brief  : Scoreboard bench: unit A (64-bit, step 8), unit B (32, 1).  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_imm_extend_unit;

  typedef struct packed {
    logic [63:0] ext;
    logic        c;
    logic        cv;
    logic        err;
    logic [3:0]  tag;
  } res_t;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  int   n_pass;
  int   n_total;
  res_t q_a[$];
  res_t q_b[$];

  imm_extend_unit_if #(.DATA_W(64), .TAG_W(4)) ifa ();
  imm_extend_unit_if #(.DATA_W(32), .TAG_W(4)) ifb ();

  imm_extend_unit #(.DATA_W(64), .ROT_STEP(8), .TAG_W(4)) dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (ifa)
  );

  imm_extend_unit #(.DATA_W(32), .ROT_STEP(1), .TAG_W(4)) dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t obs_a();
    res_t r;
    r.ext = ifa.ext_imm; r.c = ifa.shift_c; r.cv = ifa.shift_cv;
    r.err = ifa.imm_err; r.tag = ifa.out_tag;
    return r;
  endfunction

  function automatic res_t obs_b();
    res_t r;
    r.ext = 64'(ifb.ext_imm); r.c = ifb.shift_c; r.cv = ifb.shift_cv;
    r.err = ifb.imm_err; r.tag = ifb.out_tag;
    return r;
  endfunction

  // Drive one request on A at a negedge, record its expectation, and
  // return on the negedge after the accepting clock edge.
  task automatic send_a(input logic [2:0] src, input logic [23:0] ins,
                        input logic [3:0] tag, input res_t exp);
    int cnt;
    ifa.in_valid = 1'b1; ifa.imm_src = src; ifa.instr = ins; ifa.in_tag = tag;
    q_a.push_back(exp);
    cnt = 0;
    while (!ifa.in_ready && cnt < 50) begin @(negedge clk); cnt++; end
    if (!ifa.in_ready) begin
      n_total++;
      $display("FAIL send_a_accept: in_ready=%0b required 1 (tag %0d)", ifa.in_ready, tag);
    end
    @(negedge clk);
  endtask

  // Wait (bounded) for out_valid on A; lat counts clock edges since accept.
  task automatic wait_out_a(output int lat);
    lat = 1;
    while (!ifa.out_valid && lat < 64) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    res_t zero;
    zero = '0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    @(negedge clk);
    n_total++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", ifa.out_valid); else n_pass++;
    n_total++; if (obs_a() !== zero) $display("FAIL reset_outputs: got %h want %h", obs_a(), zero); else n_pass++;
    n_total++; if (ifa.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", ifa.in_ready); else n_pass++;
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    #1;
    n_total++; if (ifa.in_ready !== 1'b1) $display("FAIL release_in_ready_a: got %0b want 1", ifa.in_ready); else n_pass++;
    n_total++; if (ifb.in_ready !== 1'b1) $display("FAIL release_in_ready_b: got %0b want 1", ifb.in_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_modes();
    logic [2:0]  src [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd4, 3'd4, 3'd7, 3'd5};
    logic [23:0] ins [8] = '{24'h0000A5, 24'h123ABC, 24'hFFFFFE, 24'h000010,
                             24'h000A05, 24'h00FF0F, 24'h000A05, 24'hFFFFFF};
    logic [63:0] ext [8] = '{64'hA5, 64'hABC, 64'hFFFF_FFFF_FFFF_FFF8, 64'h40,
                             64'hA5, 64'hFF, 64'h0, 64'h0};
    logic        err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    res_t exp;
    int   lat;
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = '{ext: ext[i], c: 1'b0, cv: 1'b0, err: err[i], tag: 4'(i)};
      send_a(src[i], ins[i], 4'(i), exp);
      ifa.in_valid = 1'b0;
      wait_out_a(lat);
      n_total++; if (lat !== 1) $display("FAIL mode_latency[%0d]: got %0d want 1", i, lat); else n_pass++;
      if (q_a.size() == 0) begin
        n_total++; $display("FAIL mode_queue[%0d]: got empty want entry", i);
      end else begin
        exp = q_a.pop_front();
        n_total++;
        if (obs_a() !== exp) $display("FAIL mode_result[%0d]: got %h want %h", i, obs_a(), exp);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rotate();
    logic [23:0] ins [7] = '{24'h000FFF, 24'h0004FF, 24'h0000A5, 24'h000F01,
                             24'h000880, 24'h000501, 24'h000C03};
    logic [31:0] ext [7] = '{32'h0000_03FC, 32'hFF00_0000, 32'h0000_00A5, 32'h0000_0004,
                             32'h0080_0000, 32'h0040_0000, 32'h0000_0300};
    logic        c   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        cv  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int          lt  [7] = '{4, 1, 1, 4, 2, 2, 3};
    res_t exp;
    int   lat;
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp = '{ext: 64'(ext[i]), c: c[i], cv: cv[i], err: 1'b0, tag: 4'(8 + i)};
      send_a(3'd3, ins[i], 4'(8 + i), exp);
      ifa.in_valid = 1'b0;
      if (lt[i] > 1) begin
        n_total++; if (ifa.in_ready !== 1'b0) $display("FAIL rot_in_ready[%0d]: got %0b want 0", i, ifa.in_ready); else n_pass++;
      end
      wait_out_a(lat);
      n_total++; if (lat !== lt[i]) $display("FAIL rot_latency[%0d]: got %0d want %0d", i, lat, lt[i]); else n_pass++;
      if (q_a.size() == 0) begin
        n_total++; $display("FAIL rot_queue[%0d]: got empty want entry", i);
      end else begin
        exp = q_a.pop_front();
        n_total++;
        if (obs_a() !== exp) $display("FAIL rot_result[%0d]: got %h want %h", i, obs_a(), exp);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [2:0] pat = 3'b101;
    bit   done;
    done = 1'b0;
    fork
      begin : sender
        logic [23:0] ins;
        res_t        exp;
        for (int i = 0; i < N; i++) begin
          ins = 24'($urandom);
          exp = '{ext: 64'(ins[11:0]), c: 1'b0, cv: 1'b0, err: 1'b0, tag: 4'(i)};
          send_a(3'd1, ins, 4'(i), exp);
        end
        ifa.in_valid = 1'b0;
      end
      begin : collector
        int   got;
        int   cyc;
        bit   held_v;
        res_t held;
        res_t exp;
        got = 0; cyc = 0; held_v = 1'b0;
        while (got < N && cyc < 200) begin
          @(negedge clk);
          cyc++;
          if (ifa.out_valid) begin
            if (held_v) begin
              n_total++;
              if (obs_a() !== held) $display("FAIL b2b_hold: got %h want %h", obs_a(), held);
              else n_pass++;
            end
            if (ifa.out_ready) begin
              held_v = 1'b0;
              if (q_a.size() == 0) begin
                n_total++; $display("FAIL b2b_queue: got empty want entry");
              end else begin
                exp = q_a.pop_front();
                n_total++;
                if (obs_a() !== exp) $display("FAIL b2b_result[%0d]: got %h want %h", got, obs_a(), exp);
                else n_pass++;
              end
              got++;
            end else begin
              held = obs_a(); held_v = 1'b1;
            end
          end
        end
        if (got < N) begin
          n_total++; $display("FAIL b2b_timeout: got %0d results want %0d", got, N);
        end
        done = 1'b1;
      end
      begin : ready_driver
        int k;
        k = 0;
        while (!done) begin
          @(posedge clk); #1;
          ifa.out_ready = pat[k % 3];
          k++;
        end
        ifa.out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    n_total++; if (ifa.out_valid !== 1'b0) $display("FAIL b2b_no_dup: out_valid=%0b want 0", ifa.out_valid); else n_pass++;
    n_total++; if (q_a.size() != 0) $display("FAIL b2b_drained: queue size %0d want 0", q_a.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_rot();
    res_t exp;
    int   lat;
    ifb.out_ready = 1'b1;
    ifb.in_valid = 1'b1; ifb.imm_src = 3'd3; ifb.instr = 24'h000FFF; ifb.in_tag = 4'd5;
    n_total++; if (ifb.in_ready !== 1'b1) $display("FAIL midrot_ready: got %0b want 1", ifb.in_ready); else n_pass++;
    @(negedge clk);
    ifb.in_valid = 1'b0;
    n_total++; if (ifb.in_ready !== 1'b0) $display("FAIL midrot_busy: got %0b want 0", ifb.in_ready); else n_pass++;
    repeat (5) @(negedge clk);
    #2 rst_b_n = 1'b0;
    #1;
    n_total++; if (ifb.out_valid !== 1'b0) $display("FAIL midrot_reset_valid: got %0b want 0", ifb.out_valid); else n_pass++;
    n_total++; if (ifb.in_ready !== 1'b0) $display("FAIL midrot_reset_ready: got %0b want 0", ifb.in_ready); else n_pass++;
    @(negedge clk);
    rst_b_n = 1'b1;
    @(negedge clk);
    n_total++; if (ifb.in_ready !== 1'b1) $display("FAIL midrot_release_ready: got %0b want 1", ifb.in_ready); else n_pass++;
    // imm8=02, r=6 on a 1-bit/cycle rotator: six edges of latency.
    q_b.push_back('{ext: 64'h0800_0000, c: 1'b0, cv: 1'b1, err: 1'b0, tag: 4'd9});
    ifb.in_valid = 1'b1; ifb.imm_src = 3'd3; ifb.instr = 24'h000302; ifb.in_tag = 4'd9;
    @(negedge clk);
    ifb.in_valid = 1'b0;
    lat = 1;
    while (!ifb.out_valid && lat < 64) begin @(negedge clk); lat++; end
    n_total++; if (lat !== 6) $display("FAIL midrot_next_latency: got %0d want 6", lat); else n_pass++;
    if (q_b.size() == 0) begin
      n_total++; $display("FAIL midrot_queue: got empty want entry");
    end else begin
      exp = q_b.pop_front();
      n_total++;
      if (obs_b() !== exp) $display("FAIL midrot_next_result: got %h want %h", obs_b(), exp);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.instr = '0; ifa.imm_src = '0; ifa.in_tag = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.instr = '0; ifb.imm_src = '0; ifb.in_tag = '0; ifb.out_ready = 1'b1;
    test_reset();
    test_modes();
    test_rotate();
    test_back_to_back();
    test_reset_mid_rot();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
